// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1:NUM_CH stream demultiplexer with packet-locked
// routing, valid/ready handshake and a saturating drop counter for beats whose
// select is out of range.
// Optional per-channel drain counters are enabled by `define STREAM_DEMUX_BEAT_CNT_EN.
module stream_demux_n #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_last,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt
`ifdef STREAM_DEMUX_BEAT_CNT_EN
  ,
  input  logic                    cnt_clr,
  output logic [NUM_CH*CNT_W-1:0] beat_cnt
`else
  // no beat counter ports in this build
`endif
);

  localparam logic [0:0]       STATE_IDLE = 1'b0;
  localparam logic [0:0]       STATE_PKT  = 1'b1;
  localparam logic [SEL_W:0]   NUM_CH_L   = (SEL_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] DROP_MAX   = {CNT_W{1'b1}};

  logic [0:0]        state_q,     state_d;
  logic [SEL_W-1:0]  sel_q,       sel_d;
  logic [NUM_CH-1:0] out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_last_q,  out_last_d;
  logic [CNT_W-1:0]  drop_cnt_q,  drop_cnt_d;

  logic [SEL_W-1:0]  eff_sel_c;
  logic              in_range_c;
  logic [NUM_CH-1:0] sel_onehot_c;
  logic              hold_full_c;
  logic              drain_c;
  logic              accept_c;

  // Hold register is full iff one channel valid is set; out_valid is one-hot,
  // so the drain handshake is just the OR of the per-channel handshakes.
  assign hold_full_c = |out_valid_q;
  assign drain_c     = |(out_valid_q & out_ready);
  assign in_ready    = !hold_full_c || drain_c;
  assign accept_c    = in_valid && in_ready;

  // Effective select: live in_sel at packet start, locked select mid-packet.
  always_comb begin
    eff_sel_c    = (state_q == STATE_PKT) ? sel_q : in_sel;
    in_range_c   = ({1'b0, eff_sel_c} < NUM_CH_L);
    sel_onehot_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      sel_onehot_c[k] = (eff_sel_c == SEL_W'(k));
    end
  end

  // Next-state: packet-lock FSM, hold register load/drain, drop counter.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    drop_cnt_d  = drop_cnt_q;

    if (drain_c) begin
      out_valid_d = '0;
    end

    if (accept_c) begin
      if (in_range_c) begin
        out_valid_d = sel_onehot_c;
        out_data_d  = in_data;
        out_last_d  = in_last;
      end else if (drop_cnt_q != DROP_MAX) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end

      case (state_q)
        STATE_IDLE: begin
          if (!in_last) begin
            state_d = STATE_PKT;
            sel_d   = in_sel;
          end
        end
        STATE_PKT: begin
          if (in_last) begin
            state_d = STATE_IDLE;
          end
        end
        default: state_d = STATE_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STATE_IDLE;
      sel_q       <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == STATE_PKT);
  assign drop_cnt  = drop_cnt_q;

`ifdef STREAM_DEMUX_BEAT_CNT_EN
  logic [NUM_CH*CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Per-channel drain counters; clear wins over a same-cycle increment.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (cnt_clr) begin
        beat_cnt_d[k*CNT_W +: CNT_W] = '0;
      end else if (out_valid_q[k] && out_ready[k]) begin
        beat_cnt_d[k*CNT_W +: CNT_W] = beat_cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  // Beat counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`else
  // beat counters absent in this build
`endif

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Parametrised, registered 1:N stream demultiplexer with valid/ready handshake and packet-locked routing. Successor to the combinational 1:16 demux tree.
- Routes each input beat to one of NUM_CH output channels selected by in_sel.
- Holds the route for a whole packet, which ends at in_last.
- Sits between a single producer and NUM_CH consumer channels; one register stage gives full throughput with backpressure.

Parameters:
- NUM_CH, 16, number of output channels (2..64).
- SEL_W, 4, select width; must satisfy 2**SEL_W >= NUM_CH.
- DATA_W, 8, payload width.
- CNT_W, 8, width of the drop counter and of the optional beat counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid & in_ready.
- in_data  input  DATA_W  input payload.
- in_sel  input  SEL_W  destination channel; sampled only on the first beat of a packet.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  NUM_CH  one-hot per-channel valid.
- out_ready  input  NUM_CH  per-channel ready.
- out_data  output  DATA_W  shared payload bus, valid for the channel whose out_valid is set.
- out_last  output  1  last flag of the held beat.
- busy  output  1  high while a packet is in progress (state PKT).
- drop_cnt  output  CNT_W  saturating count of beats dropped because of an out-of-range select.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_last=0, busy=0, drop_cnt=0. State=IDLE, locked select=0, hold register empty. Takes effect immediately, including mid-packet; a partial packet is discarded with no flush.
- Hold register: one entry holding data, last and channel index.
  - in_ready = !hold_full || out_ready[hold_ch]. This is combinational from out_ready; there is no combinational path from in_valid.
- Effective select:
  - IDLE: eff_sel = in_sel.
  - PKT: eff_sel = sel_q, the value locked at packet start. in_sel is ignored.
- State machine:
  - IDLE -> PKT on an accepted beat with in_last=0; sel_q <= in_sel.
  - IDLE stays IDLE on an accepted beat with in_last=1 (single-beat packet).
  - PKT -> IDLE on an accepted beat with in_last=1.
  - busy = (state==PKT).
- Accepted beat, eff_sel < NUM_CH:
  - Loaded into the hold register at the next edge.
  - out_valid[eff_sel] rises the next cycle. Latency is exactly 1 cycle.
- Accepted beat, eff_sel >= NUM_CH:
  - Beat is consumed and discarded; the hold register is not loaded.
  - drop_cnt increments, saturating at 2**CNT_W-1.
  - The packet-lock rules still apply, so the whole packet is dropped.
  - If the hold register drains on the same edge, out_valid goes to 0.
- Hold register drain: when out_valid[hold_ch] & out_ready[hold_ch].
  - Simultaneous drain and accept: the register reloads in the same edge, sustaining one beat per cycle.
  - Drain with no accept: out_valid clears.
- out_ready bits of non-selected channels are ignored.
- While out_valid is set and out_ready is low, out_data and out_last hold stable and out_valid stays asserted.
- At most one out_valid bit is ever set.
- Beat order is preserved; there is no reordering across channels.

Optional Feature:
- Macro: STREAM_DEMUX_BEAT_CNT_EN.
- Defined:
  - Adds output beat_cnt, width NUM_CH*CNT_W. Channel k's counter occupies bits [k*CNT_W +: CNT_W].
  - The counter increments on each drain handshake of channel k, wraps modulo 2**CNT_W, and resets to 0.
  - Adds input cnt_clr, 1 bit, which synchronously clears all counters. A clear and an increment in the same cycle give 0.
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- Reset, then idle: out_valid=0, in_ready=1, drop_cnt=0. Assert rst_n=0 mid-packet: out_valid clears immediately and busy=0.
- Single-beat packets with in_sel=0..15, data=0xA0+sel, last=1, all out_ready=1: each beat appears on out_valid bit sel one cycle later with out_data=0xA0+sel; 16 beats in 16 cycles.
- 4-beat packet: in_sel=5 on beat 0, then in_sel changed to 9 on beats 1-3. All 4 beats go to channel 5; busy=1 from after beat 0 until after beat 3.
- Backpressure: out_ready[3]=0 for 5 cycles with a beat held for channel 3. in_ready=0, out_data stable, out_valid[3] held. When released, the next beat is accepted in the same cycle the held one drains.
- NUM_CH=12, in_sel=13, 3-beat packet: no out_valid asserted, drop_cnt=3. After 2**CNT_W+2 single-beat dropped packets, drop_cnt holds at 255.
- STREAM_DEMUX_BEAT_CNT_EN defined: 7 beats to channel 2 give beat_cnt[2]=7. Pulsing cnt_clr in the same cycle as a drain gives 0.
